esm_issue_buffer: RTL and testbench



---
 rtl/esm_issue_buffer_pkg.sv | 27 ++
 rtl/esm_scoreboard.sv | 53 +++++
 rtl/esm_issue_buffer.sv | 140 ++++++++++++++
 tb/tb_esm_issue_buffer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/esm_issue_buffer_pkg.sv
// Shared sizes, RV32 register-field positions and field extractors for the
// ESM issue buffer and its scoreboard.
package esm_issue_buffer_pkg;

    localparam int INSTR_W = 32;
    localparam int REGNUM  = 32;
    localparam int BS      = 16;
    localparam int IW      = $clog2(BS);
    localparam int RW      = $clog2(REGNUM);
    localparam int FIELD_W = 5;
    localparam int RD_LSB  = 7;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;

    function automatic logic [FIELD_W-1:0] get_rd(input logic [INSTR_W-1:0] instr);
        return instr[RD_LSB +: FIELD_W];
    endfunction

    function automatic logic [FIELD_W-1:0] get_rs1(input logic [INSTR_W-1:0] instr);
        return instr[RS1_LSB +: FIELD_W];
    endfunction

    function automatic logic [FIELD_W-1:0] get_rs2(input logic [INSTR_W-1:0] instr);
        return instr[RS2_LSB +: FIELD_W];
    endfunction

endpackage

// File: rtl/esm_scoreboard.sv
// Register busy bits: set by an accepted producer dispatch, cleared by writeback.
// x0 can never become busy.
module esm_scoreboard
    import esm_issue_buffer_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          set_en,
    input  logic [RW-1:0] set_rd,
    input  logic          clr_en,
    input  logic [RW-1:0] clr_rd,
    input  logic [RW-1:0] rs1_addr,
    input  logic [RW-1:0] rs2_addr,
    input  logic [RW-1:0] waw_addr,
    output logic          rs1_busy,
    output logic          rs2_busy,
    output logic          waw_busy
);

    logic [REGNUM-1:0] busy_q;
    logic [REGNUM-1:0] busy_d;

    // Next busy vector. A set and a clear of the same register can only coincide
    // when that register was idle (WAW stall), so the set wins.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_rd] = 1'b0;
        end else begin
            busy_d[clr_rd] = busy_q[clr_rd];
        end
        if (set_en) begin
            busy_d[set_rd] = 1'b1;
        end else begin
            busy_d[set_rd] = busy_d[set_rd];
        end
        busy_d[0] = 1'b0;
    end

    // Busy-bit register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= {REGNUM{1'b0}};
        end else begin
            busy_q <= busy_d;
        end
    end

    assign rs1_busy = busy_q[rs1_addr];
    assign rs2_busy = busy_q[rs2_addr];
    assign waw_busy = busy_q[waw_addr];

endmodule

// File: rtl/esm_issue_buffer.sv
// Issue buffer: slot-addressed capture from dispatch, scoreboard-based operand
// tracking with writeback wakeup, lowest-index-first issue over valid/ready.
module esm_issue_buffer
    import esm_issue_buffer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               dispatch_valid,
    output logic               dispatch_ready,
    input  logic [INSTR_W-1:0] Instr_in,
    input  logic               ALUSrc,
    input  logic               RegWrite,
    input  logic [IW-1:0]      buffer_index,
    input  logic               wb_valid,
    input  logic [RW-1:0]      wb_rd,
    output logic               issue_valid,
    input  logic               issue_ready,
    output logic [INSTR_W-1:0] issue_instr,
    output logic               issue_ALUSrc,
    output logic               issue_RegWrite,
    output logic [IW-1:0]      issue_index,
    output logic [IW:0]        occupancy
);

    logic [BS-1:0]              valid_q, valid_d;
    logic [BS-1:0]              alusrc_q, alusrc_d;
    logic [BS-1:0]              regwrite_q, regwrite_d;
    logic [BS-1:0]              rdy1_q, rdy1_d;
    logic [BS-1:0]              rdy2_q, rdy2_d;
    logic [BS-1:0][INSTR_W-1:0] instr_q, instr_d;
    logic [IW:0]                occ_q, occ_d;

    logic [RW-1:0] in_rd_s, in_rs1_s, in_rs2_s;
    logic          rs1_busy_s, rs2_busy_s, waw_busy_s;
    logic          in_rdy1_s, in_rdy2_s, disp_fire_s, iss_fire_s;
    logic [BS-1:0] ready_s, sel_oh_s;
    logic [BS:0]   seen_s;
    logic [IW-1:0] sel_idx_s;

    assign in_rd_s  = get_rd(Instr_in);
    assign in_rs1_s = get_rs1(Instr_in);
    assign in_rs2_s = get_rs2(Instr_in);

    esm_scoreboard u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (disp_fire_s && RegWrite),
        .set_rd   (in_rd_s),
        .clr_en   (wb_valid),
        .clr_rd   (wb_rd),
        .rs1_addr (in_rs1_s),
        .rs2_addr (in_rs2_s),
        .waw_addr (in_rd_s),
        .rs1_busy (rs1_busy_s),
        .rs2_busy (rs2_busy_s),
        .waw_busy (waw_busy_s)
    );

    assign dispatch_ready = !valid_q[buffer_index]
                          && !(RegWrite && (in_rd_s != {RW{1'b0}}) && waw_busy_s);
    assign disp_fire_s    = dispatch_valid && dispatch_ready;

    // A writeback landing in the dispatch cycle counts as already ready.
    assign in_rdy1_s = (in_rs1_s == {RW{1'b0}}) || !rs1_busy_s || (wb_valid && (wb_rd == in_rs1_s));
    assign in_rdy2_s = ALUSrc || (in_rs2_s == {RW{1'b0}}) || !rs2_busy_s
                     || (wb_valid && (wb_rd == in_rs2_s));

    assign ready_s   = valid_q & rdy1_q & rdy2_q;
    assign seen_s[0] = 1'b0;

    generate
        for (genvar g = 0; g < BS; g++) begin : g_prio
            assign sel_oh_s[g]   = ready_s[g] & ~seen_s[g];
            assign seen_s[g + 1] = seen_s[g] | ready_s[g];
        end
    endgenerate

    // One-hot to index; at most one bit of sel_oh_s is set.
    always_comb begin
        sel_idx_s = {IW{1'b0}};
        for (int i = 0; i < BS; i++) begin
            sel_idx_s = sel_idx_s | (sel_oh_s[i] ? IW'(i) : {IW{1'b0}});
        end
    end

    assign issue_valid    = seen_s[BS];
    assign iss_fire_s     = issue_valid && issue_ready;
    assign issue_instr    = issue_valid ? instr_q[sel_idx_s] : {INSTR_W{1'b0}};
    assign issue_ALUSrc   = issue_valid ? alusrc_q[sel_idx_s] : 1'b0;
    assign issue_RegWrite = issue_valid ? regwrite_q[sel_idx_s] : 1'b0;
    assign issue_index    = sel_idx_s;
    assign occupancy      = occ_q;

    // Per-entry next state: capture on dispatch, otherwise wakeup and issue-free.
    always_comb begin
        valid_d    = valid_q;
        alusrc_d   = alusrc_q;
        regwrite_d = regwrite_q;
        rdy1_d     = rdy1_q;
        rdy2_d     = rdy2_q;
        instr_d    = instr_q;
        for (int i = 0; i < BS; i++) begin
            if (disp_fire_s && (buffer_index == IW'(i))) begin
                valid_d[i]    = 1'b1;
                instr_d[i]    = Instr_in;
                alusrc_d[i]   = ALUSrc;
                regwrite_d[i] = RegWrite;
                rdy1_d[i]     = in_rdy1_s;
                rdy2_d[i]     = in_rdy2_s;
            end else begin
                valid_d[i] = valid_q[i] & ~(iss_fire_s & sel_oh_s[i]);
                rdy1_d[i]  = rdy1_q[i] | (wb_valid & valid_q[i] & (get_rs1(instr_q[i]) == wb_rd));
                rdy2_d[i]  = rdy2_q[i] | (wb_valid & valid_q[i] & (get_rs2(instr_q[i]) == wb_rd));
            end
        end
        occ_d = occ_q + {{IW{1'b0}}, disp_fire_s} - {{IW{1'b0}}, iss_fire_s};
    end

    // Entry and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= {BS{1'b0}};
            alusrc_q   <= {BS{1'b0}};
            regwrite_q <= {BS{1'b0}};
            rdy1_q     <= {BS{1'b0}};
            rdy2_q     <= {BS{1'b0}};
            instr_q    <= {(BS*INSTR_W){1'b0}};
            occ_q      <= {(IW+1){1'b0}};
        end else begin
            valid_q    <= valid_d;
            alusrc_q   <= alusrc_d;
            regwrite_q <= regwrite_d;
            rdy1_q     <= rdy1_d;
            rdy2_q     <= rdy2_d;
            instr_q    <= instr_d;
            occ_q      <= occ_d;
        end
    end

endmodule

// File: tb/tb_esm_issue_buffer.sv
// Directed bench for esm_issue_buffer with an issue-order scoreboard queue.
module tb_esm_issue_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        dispatch_valid, dispatch_ready;
    logic [31:0] Instr_in;
    logic        ALUSrc, RegWrite;
    logic [3:0]  buffer_index;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        issue_valid, issue_ready;
    logic [31:0] issue_instr;
    logic        issue_ALUSrc, issue_RegWrite;
    logic [3:0]  issue_index;
    logic [4:0]  occupancy;

    typedef struct packed {
        logic [3:0]  idx;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    esm_issue_buffer dut (
        .clk            (clk),
        .rst            (rst),
        .dispatch_valid (dispatch_valid),
        .dispatch_ready (dispatch_ready),
        .Instr_in       (Instr_in),
        .ALUSrc         (ALUSrc),
        .RegWrite       (RegWrite),
        .buffer_index   (buffer_index),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .issue_instr    (issue_instr),
        .issue_ALUSrc   (issue_ALUSrc),
        .issue_RegWrite (issue_RegWrite),
        .issue_index    (issue_index),
        .occupancy      (occupancy)
    );

    function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic is_sub);
        return {(is_sub ? 7'h20 : 7'h00), rs2, rs1, 3'b000, rd, 7'h33};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Compare any handshake in this cycle against the queue head, then advance.
    task automatic step();
        exp_t e;
        #1;
        if (issue_valid && issue_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_issue", {31'd0, issue_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_issue_index", {28'd0, issue_index}, {28'd0, e.idx});
                chk("sb_issue_instr", issue_instr, e.instr);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_disp(input logic [3:0] idx, input logic [31:0] ins,
                              input logic alu, input logic rw);
        dispatch_valid = 1'b1;
        buffer_index   = idx;
        Instr_in       = ins;
        ALUSrc         = alu;
        RegWrite       = rw;
        #1;
    endtask

    task automatic idle();
        dispatch_valid = 1'b0;
        wb_valid       = 1'b0;
        RegWrite       = 1'b0;
        ALUSrc         = 1'b0;
        #1;
    endtask

    task automatic wb(input logic [4:0] r);
        wb_valid = 1'b1;
        wb_rd    = r;
        #1;
    endtask

    initial begin
        logic [31:0] add313, sub431;
        add313 = mk(5'd3, 5'd1, 5'd2, 1'b0);
        sub431 = mk(5'd4, 5'd3, 5'd1, 1'b1);

        rst = 1'b1; dispatch_valid = 1'b0; Instr_in = 32'd0; ALUSrc = 1'b0; RegWrite = 1'b0;
        buffer_index = 4'd0; wb_valid = 1'b0; wb_rd = 5'd0; issue_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_issue_valid", {31'd0, issue_valid}, 32'd0);
        chk("rst_issue_instr", issue_instr, 32'd0);
        chk("rst_issue_ctrl", {30'd0, issue_ALUSrc, issue_RegWrite}, 32'd0);
        chk("rst_issue_index", {28'd0, issue_index}, 32'd0);
        chk("rst_occupancy", {27'd0, occupancy}, 32'd0);
        chk("rst_dispatch_ready", {31'd0, dispatch_ready}, 32'd1);

        // Single dispatch to slot 5 then issue
        chk("add313_encoding_const", add313, 32'h002081B3);
        drive_disp(4'd5, add313, 1'b0, 1'b1);
        chk("t1_disp_ready", {31'd0, dispatch_ready}, 32'd1);
        exp_q.push_back('{4'd5, add313});
        step();
        idle();
        chk("t1_issue_valid", {31'd0, issue_valid}, 32'd1);
        chk("t1_issue_index", {28'd0, issue_index}, 32'd5);
        chk("t1_issue_instr", issue_instr, 32'h002081B3);
        chk("t1_issue_ctrl", {30'd0, issue_ALUSrc, issue_RegWrite}, 32'd1);
        chk("t1_occupancy", {27'd0, occupancy}, 32'd1);

        // WAW stall on x3 across the issue handshake, released after writeback
        drive_disp(4'd0, mk(5'd3, 5'd0, 5'd0, 1'b0), 1'b0, 1'b1);
        chk("waw_ready_busy", {31'd0, dispatch_ready}, 32'd0);
        issue_ready = 1'b1;
        step();
        chk("t1_occ_after_issue", {27'd0, occupancy}, 32'd0);
        chk("waw_busy_after_issue", {31'd0, dispatch_ready}, 32'd0);
        issue_ready = 1'b0;
        wb(5'd3);
        chk("waw_ready_wb_cycle", {31'd0, dispatch_ready}, 32'd0);
        step();
        wb_valid = 1'b0;
        #1;
        chk("waw_ready_after_wb", {31'd0, dispatch_ready}, 32'd1);
        exp_q.push_back('{4'd0, mk(5'd3, 5'd0, 5'd0, 1'b0)});
        step();

        // RAW: sub x4,x3,x1 waits for writeback of x3
        drive_disp(4'd1, sub431, 1'b0, 1'b1);
        chk("raw_disp_ready", {31'd0, dispatch_ready}, 32'd1);
        exp_q.push_back('{4'd1, sub431});
        step();
        idle();
        chk("raw_sel_producer", {28'd0, issue_index}, 32'd0);
        issue_ready = 1'b1;
        step();
        chk("raw_wait1", {31'd0, issue_valid}, 32'd0);
        step();
        chk("raw_wait2", {31'd0, issue_valid}, 32'd0);
        wb(5'd3);
        chk("raw_wb_cycle", {31'd0, issue_valid}, 32'd0);
        step();
        wb_valid = 1'b0;
        #1;
        chk("raw_wake_valid", {31'd0, issue_valid}, 32'd1);
        chk("raw_wake_index", {28'd0, issue_index}, 32'd1);
        step();
        chk("raw_occ_empty", {27'd0, occupancy}, 32'd0);
        issue_ready = 1'b0;
        wb(5'd4);
        step();
        idle();

        // Bypass: reader of x7 dispatched with wb_rd=7 in the same cycle
        drive_disp(4'd2, mk(5'd7, 5'd0, 5'd0, 1'b0), 1'b0, 1'b1);
        exp_q.push_back('{4'd2, mk(5'd7, 5'd0, 5'd0, 1'b0)});
        step();
        idle();
        issue_ready = 1'b1;
        step();
        issue_ready = 1'b0;
        drive_disp(4'd3, mk(5'd8, 5'd7, 5'd0, 1'b0), 1'b0, 1'b0);
        wb(5'd7);
        chk("byp_disp_ready", {31'd0, dispatch_ready}, 32'd1);
        exp_q.push_back('{4'd3, mk(5'd8, 5'd7, 5'd0, 1'b0)});
        step();
        idle();
        chk("byp_issue_valid", {31'd0, issue_valid}, 32'd1);
        chk("byp_issue_index", {28'd0, issue_index}, 32'd3);
        issue_ready = 1'b1;
        step();

        // ALUSrc: rs2 field names a busy register but is not a source
        drive_disp(4'd2, mk(5'd10, 5'd0, 5'd0, 1'b0), 1'b0, 1'b1);
        exp_q.push_back('{4'd2, mk(5'd10, 5'd0, 5'd0, 1'b0)});
        step();
        idle();
        step();
        issue_ready = 1'b0;
        drive_disp(4'd6, mk(5'd11, 5'd0, 5'd10, 1'b0), 1'b1, 1'b0);
        exp_q.push_back('{4'd6, mk(5'd11, 5'd0, 5'd10, 1'b0)});
        step();
        idle();
        chk("alu_issue_index", {28'd0, issue_index}, 32'd6);
        chk("alu_issue_ctrl", {30'd0, issue_ALUSrc, issue_RegWrite}, 32'd2);
        issue_ready = 1'b1;
        step();
        issue_ready = 1'b0;
        wb(5'd10);
        step();
        idle();

        // Dispatch into the slot being issued this cycle is refused
        drive_disp(4'd4, mk(5'd9, 5'd0, 5'd0, 1'b0), 1'b0, 1'b0);
        exp_q.push_back('{4'd4, mk(5'd9, 5'd0, 5'd0, 1'b0)});
        step();
        idle();
        chk("same_slot_sel", {28'd0, issue_index}, 32'd4);
        issue_ready = 1'b1;
        drive_disp(4'd4, mk(5'd12, 5'd0, 5'd0, 1'b0), 1'b0, 1'b0);
        chk("same_slot_ready", {31'd0, dispatch_ready}, 32'd0);
        step();
        chk("same_slot_freed", {31'd0, dispatch_ready}, 32'd1);
        idle();
        issue_ready = 1'b0;
        chk("same_slot_occ", {27'd0, occupancy}, 32'd0);

        // Fill all 16 slots under back-pressure
        for (int i = 0; i < 16; i++) begin
            drive_disp(4'(i), mk(5'(i + 1), 5'd0, 5'd0, 1'b0), 1'b0, 1'b0);
            if (i < 2) exp_q.push_back('{4'(i), mk(5'(i + 1), 5'd0, 5'd0, 1'b0)});
            step();
        end
        idle();
        chk("full_occ", {27'd0, occupancy}, 32'd16);
        chk("full_index", {28'd0, issue_index}, 32'd0);
        for (int b = 0; b < 16; b += 7) begin
            drive_disp(4'(b), mk(5'd13, 5'd0, 5'd0, 1'b0), 1'b0, 1'b0);
            chk($sformatf("full_ready_slot%0d", b), {31'd0, dispatch_ready}, 32'd0);
        end
        step();
        idle();
        chk("stall_index", {28'd0, issue_index}, 32'd0);
        chk("stall_instr", issue_instr, mk(5'd1, 5'd0, 5'd0, 1'b0));
        chk("stall_occ", {27'd0, occupancy}, 32'd16);
        issue_ready = 1'b1;
        step();
        issue_ready = 1'b0;
        chk("drain1_occ", {27'd0, occupancy}, 32'd15);
        chk("drain1_index", {28'd0, issue_index}, 32'd1);
        drive_disp(4'd0, mk(5'd14, 5'd0, 5'd0, 1'b0), 1'b0, 1'b0);
        issue_ready = 1'b1;
        chk("simul_ready", {31'd0, dispatch_ready}, 32'd1);
        step();
        idle();
        issue_ready = 1'b0;
        chk("simul_occ", {27'd0, occupancy}, 32'd15);
        chk("simul_index", {28'd0, issue_index}, 32'd0);

        // Mid-flight reset with 6 entries and 3 busy registers
        rst = 1'b1;
        #1;
        chk("clr_occ_async", {27'd0, occupancy}, 32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i < 3) drive_disp(4'(i), mk(5'(20 + i), 5'd0, 5'd0, 1'b0), 1'b0, 1'b1);
            else drive_disp(4'(i), mk(5'd0, 5'd20, 5'd21, 1'b0), 1'b0, 1'b0);
            step();
        end
        idle();
        chk("mid_occ6", {27'd0, occupancy}, 32'd6);
        chk("mid_valid_pre", {31'd0, issue_valid}, 32'd1);
        issue_ready = 1'b1;
        rst = 1'b1;
        #1;
        chk("mid_rst_occ", {27'd0, occupancy}, 32'd0);
        chk("mid_rst_valid", {31'd0, issue_valid}, 32'd0);
        step();
        rst = 1'b0;
        issue_ready = 1'b0;
        #1;
        chk("post_rst_occ", {27'd0, occupancy}, 32'd0);
        chk("post_rst_valid", {31'd0, issue_valid}, 32'd0);
        for (int r = 20; r < 23; r++) begin
            RegWrite     = 1'b1;
            Instr_in     = mk(5'(r), 5'd0, 5'd0, 1'b0);
            buffer_index = 4'(r - 20);
            #1;
            chk($sformatf("post_rst_free_x%0d", r), {31'd0, dispatch_ready}, 32'd1);
        end
        idle();
        chk("sb_queue_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
